// File: rtl/mem_port_arbiter_if.sv
// Bundle of cache-side and memory-side signals around the shared memory port.
//
// Handshake: a cache raises *_req with *_wen/*_addr/*_wdata and holds it until
// its *_ready pulses for one cycle (with *_rdata valid in that cycle), then drops
// req in that same cycle. The memory sees mem_read/mem_write held with stable
// mem_addr/mem_wdata until it returns a single-cycle mem_ready (mem_rdata valid).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_req;
  logic              i_wen;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  i_req, i_wen, i_addr, i_wdata,
    input  d_req, d_wen, d_addr, d_wdata,
    input  mem_ready, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  // Caches-plus-memory view (what drives the arbiter)
  modport master (
    output i_req, i_wen, i_addr, i_wdata,
    output d_req, d_wen, d_addr, d_wdata,
    output mem_ready, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port between the
// I-cache and D-cache. One transaction at a time: IDLE -> BUSY -> DONE -> IDLE.
// All memory and cache-side outputs are decodes of registers only.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic       clk,
  input  logic       rst,
  mem_port_arbiter_if.slave bus,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q;
  logic              owner_q;   // 0 = I-cache, 1 = D-cache
  logic              last_q;    // owner of the last completed transaction
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rbuf_q;

  logic any_req;
  logic winner;

  // Pick the winner: a lone requester wins, contention goes to the non-last side
  always_comb begin
    any_req = bus.i_req | bus.d_req;
    winner  = 1'b0;
    if (bus.i_req && bus.d_req) begin
      winner = ~last_q;
    end else if (bus.d_req) begin
      winner = 1'b1;
    end
  end

  // Transaction FSM with request latch and read-data buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            wen_q   <= winner ? bus.d_wen   : bus.i_wen;
            addr_q  <= winner ? bus.d_addr  : bus.i_addr;
            wdata_q <= winner ? bus.d_wdata : bus.i_wdata;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            rbuf_q  <= bus.mem_rdata;
            last_q  <= owner_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output decodes; strobes drop as soon as state leaves BUSY (including reset)
  assign bus.mem_read  = (state_q == BUSY) & ~wen_q;
  assign bus.mem_write = (state_q == BUSY) &  wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ready   = (state_q == DONE) & ~owner_q;
  assign bus.d_ready   = (state_q == DONE) &  owner_q;
  assign bus.i_rdata   = rbuf_q;
  assign bus.d_rdata   = rbuf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand sequences for
// reset/contention corners, then randomized traffic against a reference model.
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_req = 1'b0; bus.i_wen = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.d_req = 1'b0; bus.d_wen = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    rst = 1'b1;
    tick();
    tick();
    chk_b("rst_i_ready", bus.i_ready, 1'b0);
    chk_b("rst_d_ready", bus.d_ready, 1'b0);
    chk_b("rst_mem_read", bus.mem_read, 1'b0);
    chk_b("rst_mem_write", bus.mem_write, 1'b0);
    chk_a("rst_mem_addr", bus.mem_addr, '0);
    chk_w("rst_mem_wdata", bus.mem_wdata, '0);
    chk_w("rst_i_rdata", bus.i_rdata, '0);
    chk_w("rst_d_rdata", bus.d_rdata, '0);
    chk_b("rst_state_idle", dbg_state == 2'd0, 1'b1);
    rst = 1'b0;
  endtask

  // Runs one transaction from an IDLE cycle whose requests are already driven.
  // Expected read data comes from exp_q.
  task automatic serve(input int wt, input logic [DW-1:0] rd, input logic eo,
                       input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ewd,
                       input bit drop, input bit scribble, output int done_cyc);
    logic [DW-1:0] exp_rd;
    tick();
    for (int w = 0; w <= wt; w++) begin
      chk_b("busy_mem_read", bus.mem_read, ~ew);
      chk_b("busy_mem_write", bus.mem_write, ew);
      chk_a("busy_mem_addr", bus.mem_addr, ea);
      chk_w("busy_mem_wdata", bus.mem_wdata, ewd);
      chk_b("busy_no_ready", bus.i_ready | bus.d_ready, 1'b0);
      if (scribble) begin
        bus.i_wen   = 1'($urandom);
        bus.d_wen   = 1'($urandom);
        bus.i_addr  = AW'($urandom);
        bus.d_addr  = AW'($urandom);
        bus.i_wdata = {$urandom, $urandom, $urandom, $urandom};
        bus.d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (w == wt) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
      end else begin
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 (cycle %0d)", cyc);
      exp_rd = '0;
    end else begin
      exp_rd = exp_q.pop_front();
    end
    chk_b("done_i_ready", bus.i_ready, ~eo);
    chk_b("done_d_ready", bus.d_ready, eo);
    chk_w("done_i_rdata", bus.i_rdata, exp_rd);
    chk_w("done_d_rdata", bus.d_rdata, exp_rd);
    chk_b("done_no_strobe", bus.mem_read | bus.mem_write, 1'b0);
    done_cyc = cyc;
    if (drop) begin
      if (eo) bus.d_req = 1'b0;
      else    bus.i_req = 1'b0;
    end
    tick();
    chk_b("after_no_ready", bus.i_ready | bus.d_ready, 1'b0);
    chk_b("after_state_idle", dbg_state == 2'd0, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          ir, iw;
    logic [AW-1:0] ia;
    logic [DW-1:0] iwd;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dwd;
    int            wt;
    logic [DW-1:0] rd;
    logic          eo, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl[NV];

  initial begin
    int dc, dc1, dc2;
    logic m_last;
    logic ir, dr, iw, dw, eo;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] iwd, dwd, rd;
    int wt;

    // ins: ir iw ia iwd | dr dw da dwd | wait rdata | exp: owner wen addr wdata
    tbl[0] = '{1'b1, 1'b0, 28'h0000010, '0, 1'b0, 1'b0, 28'h0, '0, 0,
               128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF, 1'b0, 1'b0, 28'h0000010, '0};
    tbl[1] = '{1'b0, 1'b0, 28'h0, '0, 1'b1, 1'b1, 28'h00000A0, {32{4'h1}}, 3,
               128'h5, 1'b1, 1'b1, 28'h00000A0, {32{4'h1}}};
    tbl[2] = '{1'b1, 1'b0, 28'h0000030, '0, 1'b1, 1'b0, 28'h0000040, '0, 0,
               128'h30, 1'b0, 1'b0, 28'h0000030, '0};
    tbl[3] = '{1'b1, 1'b1, 28'h0000050, {32{4'hA}}, 1'b1, 1'b0, 28'h0000060, {32{4'h3}}, 1,
               128'h60, 1'b1, 1'b0, 28'h0000060, {32{4'h3}}};
    tbl[4] = '{1'b1, 1'b0, 28'h0000070, {32{4'h7}}, 1'b1, 1'b1, 28'h0000080, {32{4'h5}}, 0,
               128'h70, 1'b0, 1'b0, 28'h0000070, {32{4'h7}}};
    tbl[5] = '{1'b0, 1'b0, 28'h0, '0, 1'b1, 1'b0, 28'hFFFFFFF, {32{4'hC}}, 2,
               {DW{1'b1}}, 1'b1, 1'b0, 28'hFFFFFFF, {32{4'hC}}};
    tbl[6] = '{1'b1, 1'b1, 28'h0000000, {DW{1'b1}}, 1'b0, 1'b0, 28'h0, '0, 1,
               128'h6, 1'b0, 1'b1, 28'h0000000, {DW{1'b1}}};

    // ---- table-driven transactions ----
    do_reset();
    for (int v = 0; v < NV; v++) begin
      bus.i_req = tbl[v].ir; bus.i_wen = tbl[v].iw; bus.i_addr = tbl[v].ia; bus.i_wdata = tbl[v].iwd;
      bus.d_req = tbl[v].dr; bus.d_wen = tbl[v].dw; bus.d_addr = tbl[v].da; bus.d_wdata = tbl[v].dwd;
      exp_q.push_back(tbl[v].rd);
      serve(tbl[v].wt, tbl[v].rd, tbl[v].eo, tbl[v].ew, tbl[v].ea, tbl[v].ewd, 1'b1, 1'b0, dc);
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
    end

    // ---- contention right after reset: I first, D next, 3 cycles apart ----
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 28'h0000111; bus.i_wdata = 128'h1;
    bus.d_req = 1'b1; bus.d_addr = 28'h0000222; bus.d_wdata = 128'h2;
    exp_q.push_back(128'hAAA1);
    serve(0, 128'hAAA1, 1'b0, 1'b0, 28'h0000111, 128'h1, 1'b1, 1'b0, dc1);
    exp_q.push_back(128'hBBB2);
    serve(0, 128'hBBB2, 1'b1, 1'b0, 28'h0000222, 128'h2, 1'b1, 1'b0, dc2);
    checks++;
    if (dc2 - dc1 != 3) begin
      errors++;
      $display("FAIL ready_spacing: got %0d expected 3", dc2 - dc1);
    end

    // ---- continuous contention for 6 transactions: I D I D I D ----
    do_reset();
    bus.i_req = 1'b1; bus.i_wen = 1'b0; bus.i_addr = 28'h0000100; bus.i_wdata = 128'h11;
    bus.d_req = 1'b1; bus.d_wen = 1'b1; bus.d_addr = 28'h0000200; bus.d_wdata = 128'h22;
    for (int t = 0; t < 6; t++) begin
      eo = 1'(t % 2);
      rd = 128'(t + 100);
      exp_q.push_back(rd);
      serve(0, rd, eo, eo, eo ? 28'h0000200 : 28'h0000100, eo ? 128'h22 : 128'h11,
            1'b0, 1'b0, dc);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;

    // ---- request inputs change during BUSY: latched address stays ----
    do_reset();
    bus.i_req = 1'b1; bus.i_wen = 1'b0; bus.i_addr = 28'h0000010; bus.i_wdata = '0;
    tick();
    chk_a("hold_addr_first", bus.mem_addr, 28'h0000010);
    bus.i_addr = 28'h0000020;
    bus.i_wdata = {DW{1'b1}};
    bus.i_wen = 1'b1;
    tick();
    chk_a("hold_addr_busy", bus.mem_addr, 28'h0000010);
    chk_w("hold_wdata_busy", bus.mem_wdata, '0);
    chk_b("hold_still_read", bus.mem_read, 1'b1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hC0DE;
    tick();
    bus.mem_ready = 1'b0;
    chk_b("hold_i_ready", bus.i_ready, 1'b1);
    chk_w("hold_i_rdata", bus.i_rdata, 128'hC0DE);
    bus.i_req = 1'b0;
    tick();

    // ---- reset in the middle of BUSY ----
    do_reset();
    bus.i_req = 1'b1; bus.i_wen = 1'b0; bus.i_addr = 28'h0000010;
    tick();
    chk_b("abort_busy_read", bus.mem_read, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_b("abort_read_drop", bus.mem_read, 1'b0);
    chk_b("abort_no_ready", bus.i_ready | bus.d_ready, 1'b0);
    chk_b("abort_state_idle", dbg_state == 2'd0, 1'b1);
    tick();
    rst = 1'b0;
    bus.i_req = 1'b0;
    tick();
    chk_b("abort_after_no_ready", bus.i_ready | bus.d_ready, 1'b0);
    chk_b("abort_after_idle", dbg_state == 2'd0, 1'b1);
    bus.d_req = 1'b1; bus.d_wen = 1'b0; bus.d_addr = 28'h0000123; bus.d_wdata = 128'h9;
    exp_q.push_back(128'hFACE);
    serve(1, 128'hFACE, 1'b1, 1'b0, 28'h0000123, 128'h9, 1'b1, 1'b0, dc);

    // ---- randomized traffic vs reference model ----
    do_reset();
    m_last = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.mem_ready = 1'($urandom);
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        tick();
        bus.mem_ready = 1'b0;
        chk_b("idle_no_strobe", bus.mem_read | bus.mem_write, 1'b0);
        chk_b("idle_no_ready", bus.i_ready | bus.d_ready, 1'b0);
        chk_b("idle_state", dbg_state == 2'd0, 1'b1);
      end
      case ($urandom_range(1, 3))
        1: begin ir = 1'b1; dr = 1'b0; end
        2: begin ir = 1'b0; dr = 1'b1; end
        default: begin ir = 1'b1; dr = 1'b1; end
      endcase
      iw  = 1'($urandom);
      dw  = 1'($urandom);
      ia  = AW'($urandom);
      da  = AW'($urandom);
      iwd = {$urandom, $urandom, $urandom, $urandom};
      dwd = {$urandom, $urandom, $urandom, $urandom};
      rd  = {$urandom, $urandom, $urandom, $urandom};
      wt  = $urandom_range(0, 3);
      // Reference: lone requester wins; under contention the side that did not
      // finish last wins.
      if (ir && dr) eo = ~m_last;
      else          eo = dr;
      m_last = eo;
      bus.i_req = ir; bus.i_wen = iw; bus.i_addr = ia; bus.i_wdata = iwd;
      bus.d_req = dr; bus.d_wen = dw; bus.d_addr = da; bus.d_wdata = dwd;
      exp_q.push_back(rd);
      serve(wt, rd, eo, eo ? dw : iw, eo ? da : ia, eo ? dwd : iwd, 1'b1, 1'b1, dc);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();

    // ---- final report ----
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
